// File: rtl/alu_pkg.sv
// Shared definitions for the sequential accumulator ALU: opcodes, FSM states
// and the bit positions of the {V,C,N,Z} flag vector.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_CLR  = 4'd9;
    localparam logic [3:0] OP_ON   = 4'd10;
    localparam logic [3:0] OP_OFF  = 4'd11;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/alu_iter_mult.sv
// Iterative shift-add multiplier: one partial-product step per cycle, W steps.
// done/product are valid combinationally during the final step's cycle.
module alu_iter_mult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] r_mcand;
    logic [2*W-1:0] r_prod;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] w_prod_next;

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    // Exposing the final step's sum lets the owner capture it on the same edge.
    assign done        = (r_cnt == CW'(1));
    assign product     = w_prod_next;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (rst) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_mcand  <= {{W{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= CW'(W);
        end else if (r_cnt != '0) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Accumulator ALU with valid/ready commands, {V,C,N,Z} flags, an ON/OFF power
// state and a W-cycle iterative multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [OPW-1:0] opcode,
    input  logic [W-1:0]   din,
    output logic [W-1:0]   acc,
    output logic [3:0]     flags,
    output logic           done,
    output logic           pwr,
    output logic           busy
);
    state_t         r_state;
    logic [W-1:0]   r_acc;
    logic [3:0]     r_flags;
    logic           r_done;
    logic           r_pwr;
    logic           r_busy;

    logic           w_mul_start;
    logic           w_mul_done;
    logic [2*W-1:0] w_product;
    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic           w_wr;
    logic [W-1:0]   w_res;
    logic           w_c;
    logic           w_v;
    logic [3:0]     w_flags;
    logic [3:0]     w_mul_flags;

    assign op_ready    = (r_state != ST_MUL);
    assign w_mul_start = op_valid && (r_state == ST_IDLE) && (opcode == OP_MUL);

    alu_iter_mult #(.W(W)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (r_acc),
        .b       (din),
        .done    (w_mul_done),
        .product (w_product)
    );

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        w_sum  = {1'b0, r_acc} + {1'b0, din};
        w_diff = {1'b0, r_acc} - {1'b0, din};
        w_wr   = 1'b1;
        w_res  = r_acc;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (opcode)
            OP_LOAD: w_res = din;
            OP_ADD: begin
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = (r_acc[W-1] == din[W-1]) && (w_sum[W-1] != r_acc[W-1]);
            end
            OP_SUB: begin
                w_res = w_diff[W-1:0];
                w_c   = w_diff[W];
                w_v   = (r_acc[W-1] != din[W-1]) && (w_diff[W-1] != r_acc[W-1]);
            end
            OP_AND:  w_res = r_acc & din;
            OP_OR:   w_res = r_acc | din;
            OP_XOR:  w_res = r_acc ^ din;
            OP_NOT:  w_res = ~r_acc;
            OP_CLR:  w_res = '0;
            default: w_wr  = 1'b0;
        endcase

        w_flags        = '0;
        w_flags[FLG_Z] = (w_res == '0);
        w_flags[FLG_N] = w_res[W-1];
        w_flags[FLG_C] = w_c;
        w_flags[FLG_V] = w_v;

        w_mul_flags        = '0;
        w_mul_flags[FLG_Z] = (w_product[W-1:0] == '0);
        w_mul_flags[FLG_N] = w_product[W-1];
        w_mul_flags[FLG_C] = (w_product[2*W-1:W] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_flags <= '0;
            r_done  <= 1'b0;
            r_pwr   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (opcode == OP_MUL) begin
                            r_state <= ST_MUL;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            if (opcode == OP_OFF) begin
                                r_state <= ST_OFF;
                                r_pwr   <= 1'b0;
                            end
                            if (w_wr) begin
                                r_acc   <= w_res;
                                r_flags <= w_flags;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_acc   <= w_product[W-1:0];
                        r_flags <= w_mul_flags;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_OFF: begin
                    // Anything other than ON is accepted here and dropped.
                    if (op_valid && (opcode == OP_ON)) begin
                        r_state <= ST_IDLE;
                        r_pwr   <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign acc   = r_acc;
    assign flags = r_flags;
    assign done  = r_done;
    assign pwr   = r_pwr;
    assign busy  = r_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random commands,
// checked against an arithmetic reference model of the accumulator.
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_LOAD = 4'd1;
    localparam logic [3:0] C_ADD  = 4'd2;
    localparam logic [3:0] C_SUB  = 4'd3;
    localparam logic [3:0] C_MUL  = 4'd4;
    localparam logic [3:0] C_AND  = 4'd5;
    localparam logic [3:0] C_OR   = 4'd6;
    localparam logic [3:0] C_XOR  = 4'd7;
    localparam logic [3:0] C_NOT  = 4'd8;
    localparam logic [3:0] C_CLR  = 4'd9;
    localparam logic [3:0] C_ON   = 4'd10;
    localparam logic [3:0] C_OFF  = 4'd11;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  opcode;
    logic [7:0]  din;
    logic [7:0]  acc;
    logic [3:0]  flags;
    logic        done;
    logic        pwr;
    logic        busy;

    logic        op_valid16;
    logic        op_ready16;
    logic [3:0]  opcode16;
    logic [15:0] din16;
    logic [15:0] acc16;
    logic [3:0]  flags16;
    logic        done16;
    logic        pwr16;
    logic        busy16;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_acc   = 0;
    logic [3:0] m_flags = 4'h0;
    bit         m_off   = 1'b0;

    alu_seq #(.W(8), .OPW(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .din(din), .acc(acc), .flags(flags),
        .done(done), .pwr(pwr), .busy(busy)
    );

    alu_seq #(.W(16), .OPW(4)) dut16 (
        .clk(clk), .rst(rst), .op_valid(op_valid16), .op_ready(op_ready16),
        .opcode(opcode16), .din(din16), .acc(acc16), .flags(flags16),
        .done(done16), .pwr(pwr16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic logic [3:0] mk_flags(input int r, input bit c, input bit v);
        return {v, c, (r >= 128), (r == 0)};
    endfunction

    task automatic check_state(input string tag, input int exp_done);
        check({tag, "_acc"},   32'(acc),   m_acc);
        check({tag, "_flags"}, 32'(flags), 32'(m_flags));
        check({tag, "_done"},  32'(done),  exp_done);
        check({tag, "_pwr"},   32'(pwr),   m_off ? 0 : 1);
    endtask

    // Issues one command, advances past its completion and checks the outcome.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] d);
        int a;
        int r;
        int p;
        int sr;
        int lat;
        bit c;
        bit v;
        a = m_acc;
        op_valid = 1'b1;
        opcode   = op;
        din      = d;
        check({tag, "_ready"}, 32'(op_ready), 1);
        tick();
        op_valid = 1'b0;
        if (m_off) begin
            if (op == C_ON) begin
                m_off = 1'b0;
                check_state(tag, 1);
            end else begin
                check_state(tag, 0);
            end
        end else if (op == C_MUL) begin
            p = a * int'(d);
            check({tag, "_busy"},    32'(busy),     1);
            check({tag, "_noready"}, 32'(op_ready), 0);
            // Commands offered during the multiply must be ignored.
            op_valid = 1'b1;
            opcode   = C_LOAD;
            din      = 8'hAA;
            lat = 0;
            while (done !== 1'b1 && lat < W + 4) begin
                tick();
                lat++;
            end
            op_valid = 1'b0;
            m_acc   = p % 256;
            m_flags = mk_flags(m_acc, (p >= 256), 1'b0);
            check({tag, "_lat"}, lat, W);
            check_state(tag, 1);
            check({tag, "_ready_after"}, 32'(op_ready), 1);
            check({tag, "_busy_after"},  32'(busy),     0);
        end else begin
            c = 1'b0;
            v = 1'b0;
            r = a;
            case (op)
                C_LOAD: r = int'(d);
                C_ADD: begin
                    r  = a + int'(d);
                    c  = (r >= 256);
                    r  = r % 256;
                    sr = sgn8(a) + sgn8(int'(d));
                    v  = (sr > 127) || (sr < -128);
                end
                C_SUB: begin
                    c  = (int'(d) > a);
                    r  = (a - int'(d) + 256) % 256;
                    sr = sgn8(a) - sgn8(int'(d));
                    v  = (sr > 127) || (sr < -128);
                end
                C_AND: r = a & int'(d);
                C_OR:  r = a | int'(d);
                C_XOR: r = a ^ int'(d);
                C_NOT: r = 255 - a;
                C_CLR: r = 0;
                default: r = a;
            endcase
            if (op inside {C_LOAD, C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_NOT, C_CLR}) begin
                m_acc   = r;
                m_flags = mk_flags(r, c, v);
            end
            if (op == C_OFF) m_off = 1'b1;
            check_state(tag, 1);
        end
    endtask

    initial begin
        int lat;
        int n_done;
        rst        = 1'b1;
        op_valid   = 1'b0;
        opcode     = C_NOP;
        din        = '0;
        op_valid16 = 1'b0;
        opcode16   = C_NOP;
        din16      = '0;
        tick();
        tick();
        rst = 1'b0;

        check_state("reset", 0);
        check("reset_ready", 32'(op_ready), 1);
        check("reset_busy",  32'(busy),     0);

        // Back-to-back single-cycle ops and their flags
        run_op("load10",  C_LOAD, 8'h10);
        run_op("addF8",   C_ADD,  8'hF8);
        check("addF8_acc_const",   32'(acc),   32'h08);
        check("addF8_flags_const", 32'(flags), 32'b0100);
        run_op("sub09",   C_SUB,  8'h09);
        check("sub09_flags_const", 32'(flags), 32'b0110);
        run_op("load7F",  C_LOAD, 8'h7F);
        run_op("add01",   C_ADD,  8'h01);
        check("add01_flags_const", 32'(flags), 32'b1010);
        tick();
        check("idle_done_low", 32'(done), 0);

        // Multiplies
        run_op("load0C", C_LOAD, 8'h0C);
        run_op("mul05",  C_MUL,  8'h05);
        check("mul05_acc_const", 32'(acc), 32'h3C);
        run_op("load20", C_LOAD, 8'h20);
        run_op("mul10",  C_MUL,  8'h10);
        check("mul10_flags_const", 32'(flags), 32'b0101);

        // Power-off discards commands until ON
        run_op("load5A", C_LOAD, 8'h5A);
        run_op("off",    C_OFF,  8'h00);
        run_op("off_add", C_ADD, 8'h05);
        run_op("off_load", C_LOAD, 8'h33);
        run_op("on",     C_ON,   8'h00);

        // Reset in the third multiply cycle aborts without done
        run_op("load0C_b", C_LOAD, 8'h0C);
        op_valid = 1'b1;
        opcode   = C_MUL;
        din      = 8'h05;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_acc   = 0;
        m_flags = 4'h0;
        m_off   = 1'b0;
        check_state("mulrst", 0);
        check("mulrst_ready", 32'(op_ready), 1);
        check("mulrst_busy",  32'(busy),     0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("mulrst_no_done", n_done, 0);
        check("mulrst_acc_held", 32'(acc), 0);

        // Random commands against the model
        for (int i = 0; i < 60; i++) begin
            run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), 8'($urandom));
        end

        // Wide configuration multiply
        op_valid16 = 1'b1;
        opcode16   = C_LOAD;
        din16      = 16'h0100;
        tick();
        opcode16   = C_MUL;
        din16      = 16'h0100;
        tick();
        op_valid16 = 1'b0;
        check("w16_busy", 32'(busy16), 1);
        lat = 0;
        while (done16 !== 1'b1 && lat < 24) begin
            tick();
            lat++;
        end
        check("w16_lat",   lat,              16);
        check("w16_acc",   32'(acc16),       0);
        check("w16_flags", 32'(flags16),     32'b0101);
        check("w16_ready", 32'(op_ready16),  1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
